uart_tx_arbiter: RTL

Round-robin arbiter that shares one UART transmitter serializer among up to NUM_REQ byte requesters. It latches the winning requester's byte and launches it into the serializer with a one-cycle data-valid strobe. It then waits for the serializer's done pulse, or a watchdog timeout, and acknowledges the requester. It sits between the board's byte producers (UART RX echo path, status reporters, debug taps) and the single TX line driver.

---
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX serializer among NUM_REQ byte requesters.
// Latches the winner's byte, strobes it into the serializer, then acks on done or watchdog abort.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned TIMEOUT_CLKS = 2604
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic [NUM_REQ-1:0]     o_Ack,
    output logic                   o_Timeout,
    output logic                   o_Busy,
    output logic                   o_TX_DV,
    output logic [7:0]             o_TX_Byte,
    input  logic                   i_TX_Done
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    state_e             state_q;
    logic [IW-1:0]      last_q;
    logic [IW-1:0]      idx_q;
    logic [CW-1:0]      wd_cnt_q;
    logic               wd_hit_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] ack_q;
    logic               timeout_q;
    logic               busy_q;
    logic               tx_dv_q;
    logic [7:0]         tx_byte_q;

    logic [7:0]         req_byte_c [NUM_REQ];
    logic               win_vld_c;
    logic [IW-1:0]      win_idx_c;
    logic [NUM_REQ-1:0] win_oh_c;

    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IW'(sum);
    endfunction

    always_comb begin
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            req_byte_c[k] = i_Req_Byte[8*k +: 8];
        end
    end

    // Scan offsets from farthest to nearest so the requester right after last_q wins.
    always_comb begin
        win_vld_c = 1'b0;
        win_idx_c = last_q;
        for (int unsigned off = NUM_REQ; off >= 1; off--) begin
            if (i_Req[rr_index(last_q, off)]) begin
                win_vld_c = 1'b1;
                win_idx_c = rr_index(last_q, off);
            end
        end
        win_oh_c = NUM_REQ'(1) << win_idx_c;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            last_q    <= IW'(NUM_REQ - 1);
            idx_q     <= '0;
            wd_cnt_q  <= '0;
            wd_hit_q  <= 1'b0;
            grant_q   <= '0;
            ack_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
        end else begin
            ack_q     <= '0;
            timeout_q <= 1'b0;
            tx_dv_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld_c) begin
                        state_q   <= S_SEND;
                        idx_q     <= win_idx_c;
                        grant_q   <= win_oh_c;
                        tx_byte_q <= req_byte_c[win_idx_c];
                        tx_dv_q   <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_SEND: begin
                    wd_cnt_q <= '0;
                    wd_hit_q <= 1'b0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_TX_Done) begin
                        state_q <= S_RELEASE;
                        ack_q   <= grant_q;
                    end else if (wd_hit_q) begin
                        state_q   <= S_RELEASE;
                        ack_q     <= grant_q;
                        timeout_q <= 1'b1;
                    end else begin
                        // Expiry is registered: the abort decision lands one cycle after the count hits WD_LAST.
                        wd_hit_q <= (wd_cnt_q == WD_LAST);
                        if (wd_cnt_q != '1) begin
                            wd_cnt_q <= wd_cnt_q + CW'(1);
                        end
                    end
                end
                S_RELEASE: begin
                    last_q  <= idx_q;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Grant   = grant_q;
    assign o_Ack     = ack_q;
    assign o_Timeout = timeout_q;
    assign o_Busy    = busy_q;
    assign o_TX_DV   = tx_dv_q;
    assign o_TX_Byte = tx_byte_q;

endmodule
